// File: rtl/rr_index_arbiter.sv
// Round-robin arbiter: registered binary-index grant held under valid/ready backpressure.
// Optional handshake counter gnt_cnt_o enabled by macro RR_INDEX_ARBITER_GNT_CNT_EN.
module rr_index_arbiter #(
  parameter  int NUM_REQ = 5,
  localparam int IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NUM_REQ-1:0] req_i,
  output logic [IW-1:0]      gnt_idx_o,
  output logic               gnt_valid_o,
  input  logic               gnt_ready_i
`ifdef RR_INDEX_ARBITER_GNT_CNT_EN
  ,
  output logic [31:0]        gnt_cnt_o
`endif
);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] ptr_nxt, srch_ptr, srch_idx;
  logic          srch_hit, hs;

  // First set request scanning from ptr upward, wrapping at NUM_REQ (not 2^IW).
  function automatic logic [IW:0] search(input logic [IW-1:0] ptr,
                                         input logic [NUM_REQ-1:0] req);
    logic          found;
    logic [IW-1:0] idx;
    int            p;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      p = int'(ptr) + k;
      if (p >= NUM_REQ) p = p - NUM_REQ;
      if (!found && req[p]) begin
        found = 1'b1;
        idx   = IW'(p);
      end
    end
    return {found, idx};
  endfunction

  assign hs       = (state_q == GRANT) && gnt_ready_i;
  assign ptr_nxt  = (idx_q == IW'(NUM_REQ - 1)) ? '0 : idx_q + 1'b1;
  assign srch_ptr = hs ? ptr_nxt : ptr_q;
  assign {srch_hit, srch_idx} = search(srch_ptr, req_i);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (srch_hit) begin
          idx_d   = srch_idx;
          state_d = GRANT;
        end
      end
      GRANT: begin
        // Requests are ignored until the consumer takes the pending grant.
        if (hs) begin
          ptr_d = ptr_nxt;
          if (srch_hit) idx_d = srch_idx;
          else          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      idx_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
    end
  end

  assign gnt_idx_o   = idx_q;
  assign gnt_valid_o = (state_q == GRANT);

`ifdef RR_INDEX_ARBITER_GNT_CNT_EN
  logic [31:0] cnt_q, cnt_d;

  assign cnt_d = (hs && cnt_q != 32'hFFFF_FFFF) ? cnt_q + 32'd1 : cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign gnt_cnt_o = cnt_q;
`endif

endmodule

// File: tb/tb_rr_index_arbiter.sv
// Bench for rr_index_arbiter (NUM_REQ=5): directed vector table, then random traffic
// checked against a round-robin reference model.
module tb_rr_index_arbiter;
  localparam int N  = 5;
  localparam int IW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req;
  logic          rdy;
  logic [IW-1:0] gnt_idx;
  logic          gnt_valid;
`ifdef RR_INDEX_ARBITER_GNT_CNT_EN
  logic [31:0]   gnt_cnt;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  rr_index_arbiter #(.NUM_REQ(N)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_i       (req),
    .gnt_idx_o   (gnt_idx),
    .gnt_valid_o (gnt_valid),
    .gnt_ready_i (rdy)
`ifdef RR_INDEX_ARBITER_GNT_CNT_EN
    ,
    .gnt_cnt_o   (gnt_cnt)
`endif
  );

  typedef struct {
    logic          rst;
    logic [N-1:0]  req;
    logic          rdy;
    logic          ev;
    logic [IW-1:0] ei;
    string         name;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic [N-1:0] q, input logic y,
                     input logic ev, input logic [IW-1:0] ei, input string nm);
    vec_t v;
    v.rst = r; v.req = q; v.rdy = y; v.ev = ev; v.ei = ei; v.name = nm;
    tbl.push_back(v);
  endtask

  task automatic check(input string nm, input logic ev, input logic [IW-1:0] ei);
    vectors++;
    if (gnt_valid !== ev || gnt_idx !== ei) begin
      miscompares++;
      $display("FAIL %s: got valid=%0b idx=%0d, expected valid=%0b idx=%0d",
               nm, gnt_valid, gnt_idx, ev, ei);
    end
  endtask

  // Reference model state: plain integers, modulo arithmetic.
  int  m_ptr, m_idx, m_cnt;
  bit  m_val;

  function automatic int rr_pick(input int ptr, input logic [N-1:0] r);
    for (int k = 0; k < N; k++)
      if (r[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  initial begin
    rst = 1'b1; req = '0; rdy = 1'b0;

    // Reset held with all requests, then full-throughput rotation.
    add(1, 5'b11111, 0, 0, 0, "reset0");
    add(1, 5'b11111, 0, 0, 0, "reset1");
    add(0, 5'b11111, 1, 1, 0, "first_grant");
    add(0, 5'b11111, 1, 1, 1, "rot1");
    add(0, 5'b11111, 1, 1, 2, "rot2");
    add(0, 5'b11111, 1, 1, 3, "rot3");
    add(0, 5'b11111, 1, 1, 4, "rot4");
    add(0, 5'b11111, 1, 1, 0, "rot_wrap");
    add(0, 5'b11111, 1, 1, 1, "rot_after_wrap");
    // Sparse requests.
    add(1, 5'b00000, 0, 0, 0, "reset_b");
    add(0, 5'b10100, 1, 1, 2, "sparse2");
    add(0, 5'b10100, 1, 1, 4, "sparse4");
    add(0, 5'b10100, 1, 1, 2, "sparse2b");
    add(0, 5'b10100, 1, 1, 4, "sparse4b");
    // Backpressure with withdrawn request.
    add(1, 5'b00000, 0, 0, 0, "reset_c");
    add(0, 5'b00000, 0, 0, 0, "idle_noreq");
    add(0, 5'b00010, 0, 1, 1, "bp_c1");
    add(0, 5'b00010, 0, 1, 1, "bp_c2");
    add(0, 5'b00000, 0, 1, 1, "bp_drop3");
    add(0, 5'b00000, 0, 1, 1, "bp_drop4");
    add(0, 5'b00000, 0, 1, 1, "bp_drop5");
    add(0, 5'b00000, 1, 0, 1, "bp_handshake");
    add(0, 5'b11111, 0, 1, 2, "ptr_is_2");
    // Reset mid-grant dominates a handshake.
    add(1, 5'b00000, 0, 0, 0, "reset_d");
    add(0, 5'b01000, 0, 1, 3, "pend3");
    add(0, 5'b01000, 0, 1, 3, "pend3_hold");
    add(1, 5'b01000, 1, 0, 0, "rst_mid_grant");
    add(0, 5'b11000, 0, 1, 3, "after_rst_ptr0");

    foreach (tbl[i]) begin
      rst = tbl[i].rst; req = tbl[i].req; rdy = tbl[i].rdy;
      @(posedge clk); #1;
      check(tbl[i].name, tbl[i].ev, tbl[i].ei);
    end

    // Random phase from a clean reset.
    rst = 1'b1; req = '0; rdy = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    m_ptr = 0; m_idx = 0; m_val = 0; m_cnt = 0;
    for (int c = 0; c < 1000; c++) begin
      bit hs;
      int pick;
      req = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom);
      rdy = $urandom_range(0, 1) == 1;
      hs = m_val && rdy;
      if (hs) begin
        m_ptr = (m_idx + 1) % N;
        m_cnt++;
      end
      if (!m_val || hs) begin
        pick = rr_pick(m_ptr, req);
        if (pick >= 0) begin m_val = 1; m_idx = pick; end
        else m_val = 0;
      end
      @(posedge clk); #1;
      check("random", m_val, IW'(m_idx));
      if (gnt_valid && int'(gnt_idx) >= N) begin
        miscompares++;
        $display("FAIL idx_range: got idx=%0d, expected below %0d", gnt_idx, N);
      end
`ifdef RR_INDEX_ARBITER_GNT_CNT_EN
      vectors++;
      if (gnt_cnt !== 32'(m_cnt)) begin
        miscompares++;
        $display("FAIL gnt_cnt: got %0d, expected %0d", gnt_cnt, m_cnt);
      end
`endif
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
